// File: rtl/gamepad_pmod_rx.sv
`default_nettype none
// ============================================================================
// Module      : gamepad_pmod_rx
// Description : Gamepad PMOD serial receiver. Synchronises latch/clock/data,
//               shifts in one frame, checks its length and reports presence.
// Revision    : 1.0 - initial release
// ============================================================================
module gamepad_pmod_rx #(
    parameter int SYNC_STAGES = 2,
    parameter int NUM_BITS    = 24,
    parameter int TIMEOUT_W   = 21
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                pmod_latch,
    input  logic                pmod_clk,
    input  logic                pmod_data,
    output logic [NUM_BITS-1:0] buttons,
    output logic                valid,
    output logic                present,
    output logic                frame_err
);

    localparam int                     c_CNT_W    = $clog2(NUM_BITS + 2);
    localparam logic [c_CNT_W-1:0]     c_CNT_FULL = c_CNT_W'(NUM_BITS);
    localparam logic [c_CNT_W-1:0]     c_CNT_SAT  = c_CNT_W'(NUM_BITS + 1);
    localparam logic [c_CNT_W-1:0]     c_CNT_ONE  = c_CNT_W'(1);
    localparam logic [TIMEOUT_W-1:0]   c_WD_MAX   = '1;
    localparam logic [TIMEOUT_W-1:0]   c_WD_ONE   = TIMEOUT_W'(1);

    logic [SYNC_STAGES-1:0] r_sync_latch;
    logic [SYNC_STAGES-1:0] r_sync_clk;
    logic [SYNC_STAGES-1:0] r_sync_data;
    logic                   r_prev_latch;
    logic                   r_prev_clk;
    logic                   r_ev_latch;
    logic                   r_ev_clk;
    logic                   r_ev_data;

    logic [NUM_BITS-1:0]    r_shift;
    logic [c_CNT_W-1:0]     r_bit_cnt;
    logic [TIMEOUT_W-1:0]   r_wd;
    logic [NUM_BITS-1:0]    r_buttons;
    logic                   r_valid;
    logic                   r_present;
    logic                   r_frame_err;

    logic                   w_sync_latch;
    logic                   w_sync_clk;
    logic                   w_sync_data;
    logic                   w_frame_full;
    logic                   w_no_ctrl;
    logic                   w_wd_hit;

    assign w_sync_latch = r_sync_latch[SYNC_STAGES-1];
    assign w_sync_clk   = r_sync_clk[SYNC_STAGES-1];
    assign w_sync_data  = r_sync_data[SYNC_STAGES-1];

    // Edges are registered once more so the frame logic sees clean one-cycle events
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync_latch <= '0;
            r_sync_clk   <= '0;
            r_sync_data  <= '0;
            r_prev_latch <= 1'b0;
            r_prev_clk   <= 1'b0;
            r_ev_latch   <= 1'b0;
            r_ev_clk     <= 1'b0;
            r_ev_data    <= 1'b0;
        end else begin
            r_sync_latch <= {r_sync_latch[SYNC_STAGES-2:0], pmod_latch};
            r_sync_clk   <= {r_sync_clk[SYNC_STAGES-2:0], pmod_clk};
            r_sync_data  <= {r_sync_data[SYNC_STAGES-2:0], pmod_data};
            r_prev_latch <= w_sync_latch;
            r_prev_clk   <= w_sync_clk;
            r_ev_latch   <= w_sync_latch & ~r_prev_latch;
            r_ev_clk     <= w_sync_clk & ~r_prev_clk;
            r_ev_data    <= w_sync_data;
        end
    end

    assign w_frame_full = (r_bit_cnt == c_CNT_FULL);
    assign w_no_ctrl    = &r_shift;
    assign w_wd_hit     = !r_ev_latch && (r_wd == c_WD_MAX - c_WD_ONE);

    // A latch event takes priority; a coincident bit clock is dropped
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_shift     <= '0;
            r_bit_cnt   <= '0;
            r_wd        <= '0;
            r_buttons   <= '0;
            r_valid     <= 1'b0;
            r_present   <= 1'b0;
            r_frame_err <= 1'b0;
        end else begin
            r_valid     <= 1'b0;
            r_frame_err <= 1'b0;
            if (r_ev_latch) begin
                r_bit_cnt <= '0;
                if (w_frame_full) begin
                    r_valid <= 1'b1;
                    r_wd    <= '0;
                    if (w_no_ctrl) begin
                        r_buttons <= '0;
                        r_present <= 1'b0;
                    end else begin
                        r_buttons <= r_shift;
                        r_present <= 1'b1;
                    end
                end else begin
                    r_frame_err <= 1'b1;
                end
            end else begin
                if (r_ev_clk) begin
                    r_shift <= {r_shift[NUM_BITS-2:0], r_ev_data};
                    if (r_bit_cnt != c_CNT_SAT) begin
                        r_bit_cnt <= r_bit_cnt + c_CNT_ONE;
                    end
                end
                if (r_wd != c_WD_MAX) begin
                    r_wd <= r_wd + c_WD_ONE;
                end
                if (w_wd_hit) begin
                    r_present <= 1'b0;
                    r_buttons <= '0;
                end
            end
        end
    end

    assign buttons   = r_buttons;
    assign valid     = r_valid;
    assign present   = r_present;
    assign frame_err = r_frame_err;

endmodule
`default_nettype wire

// File: doc/gamepad_pmod_rx.md
Name: gamepad_pmod_rx

Overview:
- Receiver for the Gamepad PMOD serial stream on the JA header (latch, clock and data lines).
- Shifts in the button word and captures it on the latch pulse.
- Checks frame length, detects a missing or disconnected controller, and provides a clean, stable button vector to the game logic in the clk_proj domain.
- Replaces the raw JA[6:4] OR-in path at top level.

Parameters:
- SYNC_STAGES, 2, synchronizer flops per PMOD input (min 2).
- NUM_BITS, 24, bits per frame (2 controllers x 12 SNES bits).
- TIMEOUT_W, 21, width of the no-frame watchdog counter; timeout at 2^TIMEOUT_W - 1 cycles (about 83 ms at 25.175 MHz).

Ports:
- clk, input, 1, project clock (clk_proj).
- rst_n, input, 1, asynchronous active-low reset.
- pmod_latch, input, 1, async frame latch from PMOD.
- pmod_clk, input, 1, async bit clock from PMOD.
- pmod_data, input, 1, async serial data, MSB first.
- buttons, output, NUM_BITS, last good frame; bit NUM_BITS-1 = first bit received.
- valid, output, 1, one-cycle pulse when buttons is updated.
- present, output, 1, controller connected and frames arriving.
- frame_err, output, 1, one-cycle pulse on a bad-length frame.

Behaviour:

Reset (async, rst_n=0):
- All sync flops, edge-history flops, shift register, bit counter and watchdog are cleared.
- buttons=0, valid=0, present=0, frame_err=0.

Input synchronization:
- Each input passes through SYNC_STAGES flops.
- Edge history holds the previous synced value.
- rise_x = sync_x & ~prev_x.

Bit clock edge (rise_clk, no rise_latch in the same cycle):
- shift <= {shift[NUM_BITS-2:0], data_s}, where data_s is the synced data at the same stage depth as the clock.
- bit_cnt increments and saturates at NUM_BITS+1, so overlong frames remain detectable.

Latch edge (rise_latch):
- If bit_cnt == NUM_BITS and shift is not all ones (good frame):
  - buttons <= shift; valid=1 for one cycle; present <= 1; watchdog <= 0.
- If bit_cnt == NUM_BITS and shift is all ones (no controller attached):
  - buttons <= 0; present <= 0; valid=1; watchdog <= 0.
- If bit_cnt != NUM_BITS:
  - frame_err=1 for one cycle; buttons and present unchanged; valid=0.
- In all three cases bit_cnt <= 0. The shift register is not cleared.

Simultaneous rise_latch and rise_clk:
- The latch is evaluated against the pre-edge shift and bit_cnt.
- That clock edge is discarded and bit_cnt <= 0.

Watchdog:
- Increments every cycle when no latch edge occurs; saturates at all ones.
- On the cycle it reaches 2^TIMEOUT_W-1: present <= 0 and buttons <= 0. No valid pulse.
- It then stays saturated, with no repeated action, until the next good frame.

Latency:
- A pmod_latch rise sampled at clk edge k updates buttons/valid at edge k+SYNC_STAGES+1.
- With defaults this is 3 cycles.

Other rules:
- valid and frame_err are never high in the same cycle.
- Edges arriving while rst_n=0 are lost. The first latch after reset release always reports frame_err unless a full NUM_BITS clocks were seen first.

Test Plan:
1. Reset, then 24 bits of 0xA5_0F3C (MSB first), then latch:
   - buttons=24'hA50F3C, valid is a single pulse 3 cycles after latch, present=1, frame_err=0.
2. Good frame 0x000001, then a frame of 23 clocks, then latch:
   - frame_err pulses once; buttons stays 0x000001; present stays 1.
3. 25 clocks then latch:
   - frame_err pulses once (saturated count 25 != 24); the next good frame 0x123456 is accepted normally.
4. Frame of all ones (0xFFFFFF):
   - valid pulses; buttons=0; present=0. A following frame 0x000800 sets present=1 and buttons=0x000800.
5. Good frame, then no latch, with TIMEOUT_W=8 for simulation:
   - after 255 idle cycles present=0 and buttons=0, with no valid pulse.
   - the next good frame restores present=1.
6. Drive the latch rise and a clk rise in the same sampled cycle after 24 clocks; separately, assert rst_n mid-frame:
   - simultaneous case: frame accepted with pre-edge data, and the next frame needs a full 24 clocks.
   - reset case: all outputs 0 immediately (async); the first post-reset latch with fewer than 24 clocks gives frame_err.
